// File: rtl/v810_dataram_pkg.sv
// v810_dataram_pkg: shared types and width helper for the V810 cache data array
// Contents:
//   fill_state_e - line-fill sequencer states (IDLE, FILL)
//   clog2_min1   - ceil(log2(n)), never less than 1, used for the way and word port widths
package v810_dataram_pkg;

    typedef enum logic {IDLE, FILL} fill_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/v810_dataram_bank.sv
// v810_dataram_bank: one cache way, byte-laned simple dual-port RAM
// Ports:
//   clock_i, rst_ni         - clock, asynchronous active-low reset (output register only)
//   we_i, waddr_i, wbe_i,
//   wdata_i                 - write port with per-byte enables
//   re_i, raddr_i           - read request, captured into the read address register
//   oe_i                    - load the output register from the addressed word
//   rdata_o                 - registered read data (holds when oe_i is low)
//   perr_o                  - registered "some byte failed parity" flag (V810_DATARAM_PARITY_EN only)
// With V810_DATARAM_PARITY_EN each lane stores an even-parity bit above its byte.
// The array is read from the registered address one cycle after capture, so a write
// committed on the capture edge is already in the array when the word is read.
module v810_dataram_bank #(
    parameter int aw    = 8,
    parameter int lanes = 4
) (
    input  logic                 clock_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [aw-1:0]        waddr_i,
    input  logic [lanes-1:0]     wbe_i,
    input  logic [lanes*8-1:0]   wdata_i,
    input  logic                 re_i,
    input  logic [aw-1:0]        raddr_i,
    input  logic                 oe_i,
    output logic [lanes*8-1:0]   rdata_o
`ifdef V810_DATARAM_PARITY_EN
    ,
    output logic                 perr_o
`endif
);

`ifdef V810_DATARAM_PARITY_EN
    localparam int LW = 9;
`else
    localparam int LW = 8;
`endif

    logic [LW-1:0]      mem_q [2**aw][lanes];
    logic [aw-1:0]      raddr_q;
    logic [lanes*8-1:0] rdata_q;
    logic [lanes*8-1:0] rword;

    always_ff @(posedge clock_i) begin
        if (we_i)
            for (int b = 0; b < lanes; b++)
                if (wbe_i[b])
`ifdef V810_DATARAM_PARITY_EN
                    mem_q[waddr_i][b] <= {^wdata_i[b*8 +: 8], wdata_i[b*8 +: 8]};
`else
                    mem_q[waddr_i][b] <= wdata_i[b*8 +: 8];
`endif
        if (re_i)
            raddr_q <= raddr_i;
    end

`ifdef V810_DATARAM_PARITY_EN
    logic perr_c;
    logic perr_q;

    always_comb begin
        rword  = '0;
        perr_c = 1'b0;
        for (int b = 0; b < lanes; b++) begin
            rword[b*8 +: 8] = mem_q[raddr_q][b][7:0];
            perr_c          = perr_c | (^mem_q[raddr_q][b]);
        end
    end

    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else if (oe_i) begin
            rdata_q <= rword;
            perr_q  <= perr_c;
        end
    end

    assign perr_o = perr_q;
`else
    always_comb begin
        rword = '0;
        for (int b = 0; b < lanes; b++)
            rword[b*8 +: 8] = mem_q[raddr_q][b];
    end

    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni)
            rdata_q <= '0;
        else if (oe_i)
            rdata_q <= rword;
    end
`endif

    assign rdata_o = rdata_q;

endmodule

// File: rtl/v810_dataram_nway.sv
// v810_dataram_nway: N-way set-associative cache data array with line-fill sequencer
// Ports:
//   clock, reset_n                      - clock, asynchronous active-low reset
//   rd_en, rd_index, rd_word            - read request (all ways in parallel)
//   rd_data, rd_valid                   - way w at [w*data_width +: data_width], valid 2 cycles after rd_en
//   wr_en, wr_way, wr_index, wr_word,
//   wr_be, wr_data                      - CPU byte-enabled store, dropped while busy
//   fill_start, fill_way, fill_index    - start a whole-line fill into one way/set
//   fill_valid, fill_data, fill_ready   - fill word stream handshake
//   fill_done, busy                     - end-of-fill pulse, fill in progress
//   rd_perr                             - per-way parity error (V810_DATARAM_PARITY_EN only)
// Optional feature macro: V810_DATARAM_PARITY_EN.
module v810_dataram_nway
    import v810_dataram_pkg::*;
#(
    parameter int ways        = 2,
    parameter int index_width = 7,
    parameter int line_words  = 2,
    parameter int data_width  = 32
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 rd_en,
    input  logic [index_width-1:0]               rd_index,
    input  logic [clog2_min1(line_words)-1:0]    rd_word,
    output logic [ways*data_width-1:0]           rd_data,
    output logic                                 rd_valid,
    input  logic                                 wr_en,
    input  logic [clog2_min1(ways)-1:0]          wr_way,
    input  logic [index_width-1:0]               wr_index,
    input  logic [clog2_min1(line_words)-1:0]    wr_word,
    input  logic [data_width/8-1:0]              wr_be,
    input  logic [data_width-1:0]                wr_data,
    input  logic                                 fill_start,
    input  logic [clog2_min1(ways)-1:0]          fill_way,
    input  logic [index_width-1:0]               fill_index,
    input  logic                                 fill_valid,
    input  logic [data_width-1:0]                fill_data,
    output logic                                 fill_ready,
    output logic                                 fill_done,
    output logic                                 busy
`ifdef V810_DATARAM_PARITY_EN
    ,
    output logic [ways-1:0]                      rd_perr
`endif
);

    localparam int WAY_W  = clog2_min1(ways);
    localparam int WORD_W = clog2_min1(line_words);
    localparam int AW     = index_width + WORD_W;
    localparam int LANES  = data_width / 8;
    localparam logic [WORD_W-1:0] LAST = WORD_W'(line_words - 1);

    fill_state_e               state_q;
    logic [WORD_W-1:0]         cnt_q;
    logic [WAY_W-1:0]          fill_way_q;
    logic [index_width-1:0]    fill_index_q;
    logic                      fill_ready_q, fill_done_q, busy_q;
    logic                      rd_pend_q, rd_valid_q;

    // One shared write port per way: fill words win, CPU stores only while idle.
    logic                      fill_we, w_en;
    logic [WAY_W-1:0]          w_way;
    logic [AW-1:0]             w_addr;
    logic [LANES-1:0]          w_be;
    logic [data_width-1:0]     w_data;

    assign fill_we = (state_q == FILL) && fill_valid;
    assign w_en    = fill_we || (wr_en && !busy_q);
    assign w_way   = fill_we ? fill_way_q : wr_way;
    assign w_addr  = fill_we ? {fill_index_q, cnt_q} : {wr_index, wr_word};
    assign w_be    = fill_we ? {LANES{1'b1}} : wr_be;
    assign w_data  = fill_we ? fill_data : wr_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            fill_way_q   <= '0;
            fill_index_q <= '0;
            fill_ready_q <= 1'b0;
            fill_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            fill_done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (fill_start) begin
                    state_q      <= FILL;
                    fill_way_q   <= fill_way;
                    fill_index_q <= fill_index;
                    cnt_q        <= '0;
                    fill_ready_q <= 1'b1;
                    busy_q       <= 1'b1;
                end
            end else if (fill_valid) begin
                cnt_q <= cnt_q + WORD_W'(1);
                if (cnt_q == LAST) begin
                    state_q      <= IDLE;
                    fill_ready_q <= 1'b0;
                    busy_q       <= 1'b0;
                    fill_done_q  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_pend_q  <= rd_en;
            rd_valid_q <= rd_pend_q;
        end
    end

    for (genvar w = 0; w < ways; w++) begin : g_way
        v810_dataram_bank #(
            .aw    (AW),
            .lanes (LANES)
        ) u_bank (
            .clock_i (clock),
            .rst_ni  (reset_n),
            .we_i    (w_en && (w_way == WAY_W'(w))),
            .waddr_i (w_addr),
            .wbe_i   (w_be),
            .wdata_i (w_data),
            .re_i    (rd_en),
            .raddr_i ({rd_index, rd_word}),
            .oe_i    (rd_pend_q),
            .rdata_o (rd_data[w*data_width +: data_width])
`ifdef V810_DATARAM_PARITY_EN
            ,
            .perr_o  (rd_perr[w])
`endif
        );
    end

    assign rd_valid   = rd_valid_q;
    assign fill_ready = fill_ready_q;
    assign fill_done  = fill_done_q;
    assign busy       = busy_q;

endmodule
